// File: rtl/iomem_slot_ctrl.sv
// iomem bus sequencer: claims one address page, forwards each hit to one of NSLOTS
// register slots, and answers with the slot's data or an error after a bounded wait.
module iomem_slot_ctrl #(
  parameter int          NSLOTS    = 4,
  parameter logic [7:0]  BASE_PAGE = 8'h03,
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] ERR_DATA  = 32'hFFFF_FFFF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 iomem_valid,
  input  logic [3:0]           iomem_wstrb,
  input  logic [31:0]          iomem_addr,
  input  logic [31:0]          iomem_wdata,
  output logic                 iomem_ready,
  output logic [31:0]          iomem_rdata,
  output logic [NSLOTS-1:0]    slot_valid,
  output logic [3:0]           slot_wstrb,
  output logic [19:0]          slot_addr,
  output logic [31:0]          slot_wdata,
  input  logic [NSLOTS-1:0]    slot_ready,
  input  logic [32*NSLOTS-1:0] slot_rdata,
  output logic [7:0]           err_count,
  output logic [3:0]           err_slot
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [4:0] NSLOTS_W   = 5'(NSLOTS);
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  logic [1:0]        state;
  logic [7:0]        timer;
  logic [3:0]        idx_q;

  logic              hit;
  logic              idx_ok;
  logic [3:0]        req_idx;
  logic [NSLOTS-1:0] req_onehot;
  logic              sel_ready;
  logic [31:0]       sel_rdata;
  logic [7:0]        err_count_inc;

  // NOTE: every signal gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    req_idx       = iomem_addr[23:20];
    hit           = iomem_valid && (iomem_addr[31:24] == BASE_PAGE);
    idx_ok        = ({1'b0, req_idx} < NSLOTS_W);
    err_count_inc = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
    req_onehot    = '0;
    sel_ready     = 1'b0;
    sel_rdata     = '0;
    for (int i = 0; i < NSLOTS; i++) begin
      if (req_idx == 4'(i)) req_onehot[i] = 1'b1;
      if (idx_q == 4'(i)) begin
        sel_ready = slot_ready[i];
        sel_rdata = slot_rdata[32*i +: 32];
      end
    end
  end

  // NOTE: registered state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      timer       <= '0;
      idx_q       <= '0;
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
      slot_valid  <= '0;
      slot_wstrb  <= '0;
      slot_addr   <= '0;
      slot_wdata  <= '0;
      err_count   <= '0;
      err_slot    <= '0;
    end else begin
      iomem_ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (hit) begin
            slot_wstrb <= iomem_wstrb;
            slot_addr  <= iomem_addr[19:0];
            slot_wdata <= iomem_wdata;
            idx_q      <= req_idx;
            timer      <= '0;
            if (idx_ok) begin
              slot_valid <= req_onehot;
              state      <= ST_ACCESS;
            end else begin
              // Unpopulated slot index: answer immediately with an error.
              iomem_rdata <= ERR_DATA;
              err_count   <= err_count_inc;
              err_slot    <= req_idx;
              iomem_ready <= 1'b1;
              state       <= ST_RESP;
            end
          end
        end
        ST_ACCESS: begin
          timer <= timer + 8'd1;
          // A ready arriving in the last allowed cycle still wins over the timeout.
          if (sel_ready) begin
            iomem_rdata <= sel_rdata;
            slot_valid  <= '0;
            iomem_ready <= 1'b1;
            state       <= ST_RESP;
          end else if (timer == TIMER_LAST) begin
            iomem_rdata <= ERR_DATA;
            err_count   <= err_count_inc;
            err_slot    <= idx_q;
            slot_valid  <= '0;
            iomem_ready <= 1'b1;
            state       <= ST_RESP;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iomem_slot_ctrl.sv
// Self-checking bench for iomem_slot_ctrl: directed scenarios plus random traffic,
// checked against a latency/data/error model derived from the bus rules.
module tb_iomem_slot_ctrl;

  localparam int          NSLOTS    = 4;
  localparam logic [7:0]  BASE_PAGE = 8'h03;
  localparam int          TIMEOUT   = 255;
  localparam logic [31:0] ERR_DATA  = 32'hFFFF_FFFF;
  localparam int          NEVER     = 1000;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 iomem_valid;
  logic [3:0]           iomem_wstrb;
  logic [31:0]          iomem_addr;
  logic [31:0]          iomem_wdata;
  logic                 iomem_ready;
  logic [31:0]          iomem_rdata;
  logic [NSLOTS-1:0]    slot_valid;
  logic [3:0]           slot_wstrb;
  logic [19:0]          slot_addr;
  logic [31:0]          slot_wdata;
  logic [NSLOTS-1:0]    slot_ready;
  logic [32*NSLOTS-1:0] slot_rdata;
  logic [7:0]           err_count;
  logic [3:0]           err_slot;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int          m_err_count;
  logic [3:0]  m_err_slot;
  logic [31:0] m_rdata;
  logic [31:0] slot_data [NSLOTS];

  iomem_slot_ctrl #(
    .NSLOTS(NSLOTS), .BASE_PAGE(BASE_PAGE), .TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)
  ) dut (
    .clk(clk), .reset(reset),
    .iomem_valid(iomem_valid), .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
    .iomem_wdata(iomem_wdata), .iomem_ready(iomem_ready), .iomem_rdata(iomem_rdata),
    .slot_valid(slot_valid), .slot_wstrb(slot_wstrb), .slot_addr(slot_addr),
    .slot_wdata(slot_wdata), .slot_ready(slot_ready), .slot_rdata(slot_rdata),
    .err_count(err_count), .err_slot(err_slot)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One CPU transfer. delay = slot-valid cycles the slot waits before raising ready.
  task automatic do_access(input string name, input logic [31:0] addr, input logic [3:0] wstrb,
                           input logic [31:0] wdata, input int delay);
    logic [3:0]        idx;
    bit                hit, good;
    int                exp_lat, exp_vcycles, n_cycles, first, pulses, vcycles, cnt;
    bit                onehot_bad, unstable;
    logic [31:0]       exp_rdata, seen_rdata;
    logic [NSLOTS-1:0] exp_oh, noise;
    idx   = addr[23:20];
    hit   = (addr[31:24] == BASE_PAGE);
    good  = hit && (int'(idx) < NSLOTS);
    first = -1; pulses = 0; vcycles = 0; cnt = 0;
    onehot_bad = 0; unstable = 0; seen_rdata = '0;
    for (int i = 0; i < NSLOTS; i++) begin
      slot_data[i] = $urandom;
      slot_rdata[32*i +: 32] = slot_data[i];
    end
    exp_oh = '0;
    if (good) exp_oh[idx] = 1'b1;
    if (!hit) begin
      exp_lat = 0; exp_rdata = m_rdata;
    end else if (!good) begin
      exp_lat = 1; exp_rdata = ERR_DATA;
    end else if (delay < TIMEOUT) begin
      exp_lat = delay + 2; exp_rdata = slot_data[idx];
    end else begin
      exp_lat = TIMEOUT + 1; exp_rdata = ERR_DATA;
    end
    if (hit && exp_rdata === ERR_DATA && !(good && delay < TIMEOUT)) begin
      m_err_count = (m_err_count < 255) ? m_err_count + 1 : 255;
      m_err_slot  = idx;
    end
    if (hit) m_rdata = exp_rdata;
    exp_vcycles = good ? exp_lat - 1 : 0;
    n_cycles    = hit ? exp_lat + 2 : 8;

    iomem_valid = 1'b1; iomem_addr = addr; iomem_wstrb = wstrb; iomem_wdata = wdata;
    for (int n = 1; n <= n_cycles; n++) begin
      next_cycle();
      if (slot_valid !== '0) begin
        vcycles++; cnt++;
        if (slot_valid !== exp_oh) onehot_bad = 1;
        if (slot_addr !== addr[19:0] || slot_wstrb !== wstrb || slot_wdata !== wdata) unstable = 1;
      end else begin
        cnt = 0;
      end
      noise = NSLOTS'($urandom) & ~exp_oh;
      slot_ready = noise | ((cnt > 0 && cnt - 1 == delay) ? exp_oh : '0);
      if (iomem_ready === 1'b1) begin
        pulses++;
        if (first < 0) begin first = n; seen_rdata = iomem_rdata; end
        iomem_valid = 1'b0;
      end
    end
    iomem_valid = 1'b0;
    slot_ready  = '0;

    checks++;
    if (pulses !== (hit ? 1 : 0)) begin
      failures++; $display("FAIL %s ready_pulses got=%0d exp=%0d", name, pulses, hit ? 1 : 0);
    end
    if (hit) begin
      checks++;
      if (first !== exp_lat) begin
        failures++; $display("FAIL %s latency got=%0d exp=%0d", name, first, exp_lat);
      end
      checks++;
      if (seen_rdata !== exp_rdata) begin
        failures++; $display("FAIL %s rdata got=%h exp=%h", name, seen_rdata, exp_rdata);
      end
    end else begin
      checks++;
      if (iomem_rdata !== m_rdata) begin
        failures++; $display("FAIL %s rdata_hold got=%h exp=%h", name, iomem_rdata, m_rdata);
      end
    end
    checks++;
    if (vcycles !== exp_vcycles || onehot_bad || unstable) begin
      failures++;
      $display("FAIL %s slot_valid cycles=%0d exp=%0d onehot_bad=%0d unstable=%0d",
               name, vcycles, exp_vcycles, onehot_bad, unstable);
    end
    checks++;
    if (err_count !== 8'(m_err_count) || err_slot !== m_err_slot) begin
      failures++;
      $display("FAIL %s err got=%0d/%0d exp=%0d/%0d", name, err_count, err_slot, m_err_count, m_err_slot);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    checks++;
    if ({iomem_ready, iomem_rdata, slot_valid, slot_wstrb, slot_addr, slot_wdata, err_count, err_slot} !== '0) begin
      failures++;
      $display("FAIL reset_state ready=%b rdata=%h valid=%b wstrb=%h addr=%h wdata=%h errc=%0d errs=%0d",
               iomem_ready, iomem_rdata, slot_valid, slot_wstrb, slot_addr, slot_wdata, err_count, err_slot);
    end
    reset = 1'b0;
    m_err_count = 0; m_err_slot = '0; m_rdata = '0;
    next_cycle();
  endtask

  task automatic test_read_same_cycle();
    do_access("read_slot1", 32'h0310_0004, 4'b0000, 32'h0, 0);
  endtask

  task automatic test_write_delay();
    do_access("write_slot0", 32'h0300_0010, 4'b0011, 32'hA5A5_A5A5, 5);
  endtask

  task automatic test_timeout();
    do_access("timeout_slot2", 32'h0320_0000, 4'b0000, 32'h0, NEVER);
  endtask

  task automatic test_ready_at_limit();
    do_access("ready_at_limit", 32'h0330_0100, 4'b0000, 32'h0, TIMEOUT - 1);
    do_access("ready_past_limit", 32'h0310_0200, 4'b1111, 32'h1234_0000, TIMEOUT);
  endtask

  task automatic test_bad_slot_and_miss();
    do_access("bad_slot7", 32'h0370_0000, 4'b0000, 32'h0, 0);
    do_access("page_miss", 32'h0200_0000, 4'b0000, 32'h0, 0);
  endtask

  task automatic test_reset_abort();
    bit extra_ready;
    extra_ready = 0;
    iomem_valid = 1'b1; iomem_addr = 32'h0320_0008; iomem_wstrb = 4'b0000; iomem_wdata = '0;
    slot_ready = '0;
    for (int n = 1; n <= 3; n++) begin
      next_cycle();
      if (iomem_ready === 1'b1) extra_ready = 1;
    end
    reset = 1'b1;
    next_cycle();
    checks++;
    if (slot_valid !== '0 || iomem_ready !== 1'b0 || err_count !== 8'd0) begin
      failures++;
      $display("FAIL reset_abort valid=%b ready=%b errc=%0d exp=0/0/0", slot_valid, iomem_ready, err_count);
    end
    iomem_valid = 1'b0; reset = 1'b0;
    m_err_count = 0; m_err_slot = '0; m_rdata = '0;
    for (int n = 0; n < 4; n++) begin
      next_cycle();
      if (iomem_ready === 1'b1 || slot_valid !== '0) extra_ready = 1;
    end
    checks++;
    if (extra_ready) begin
      failures++; $display("FAIL reset_abort_quiet got=activity exp=none");
    end
    do_access("after_abort", 32'h0320_0000, 4'b0000, 32'h0, 1);
  endtask

  task automatic test_random();
    logic [31:0] addr;
    int          delay;
    for (int t = 0; t < 40; t++) begin
      addr = {BASE_PAGE, 4'($urandom_range(0, 7)), 20'($urandom)};
      if ($urandom_range(0, 9) == 0) addr[31:24] = 8'($urandom_range(4, 255));
      delay = ($urandom_range(0, 19) == 0) ? NEVER : int'($urandom_range(0, 12));
      do_access("random", addr, 4'($urandom), $urandom, delay);
    end
  endtask

  task automatic test_saturation();
    logic [31:0] addr;
    for (int t = 0; t < 260; t++) begin
      addr = {BASE_PAGE, 4'($urandom_range(NSLOTS, 15)), 20'($urandom)};
      do_access("sat_bad_slot", addr, 4'b0000, 32'h0, 0);
    end
    checks++;
    if (err_count !== 8'hFF) begin
      failures++; $display("FAIL saturate got=%h exp=ff", err_count);
    end
    do_access("sat_timeout", 32'h0300_0000, 4'b0000, 32'h0, NEVER);
  endtask

  initial begin
    reset = 1'b1; iomem_valid = 1'b0; iomem_wstrb = '0; iomem_addr = '0; iomem_wdata = '0;
    slot_ready = '0; slot_rdata = '0;
    m_err_count = 0; m_err_slot = '0; m_rdata = '0;
    next_cycle();
    test_reset();
    test_read_same_cycle();
    test_write_delay();
    test_timeout();
    test_ready_at_limit();
    test_bad_slot_and_miss();
    test_reset_abort();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
